// File: rtl/aes_decryptor_pkg.sv
// aes_model_pack: shared types, tables and helpers for the AES-128 decryptor.
//   byte_table      : 16-byte block, element [0] is FIPS-197 byte 0 (bits [127:120])
//   dec_state_e     : decryptor FSM encoding
//   SBOX / INV_SBOX : forward (key expansion) and inverse S-boxes
//   RCON            : key-expansion round constants
//   gf_mul()        : GF(2^8) multiply by a 4-bit constant, polynomial 0x11B
//   next_round_key(): one AES-128 key-schedule step
package aes_model_pack;

    typedef logic [0:15][7:0] byte_table;

    typedef enum logic [2:0] {IDLE, EXPAND, READY, ROUND, DONE} dec_state_e;

    localparam int NUM_ROUNDS = 10;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Constants of InvMixColumns (0x09, 0x0b, 0x0d, 0x0e) all fit in 4 bits.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic byte_table next_round_key(input byte_table prev, input logic [7:0] rcon);
        byte_table nk;
        logic [0:3][7:0] t;
        // SubWord(RotWord(w3)) ^ Rcon
        t[0] = SBOX[prev[13]] ^ rcon;
        t[1] = SBOX[prev[14]];
        t[2] = SBOX[prev[15]];
        t[3] = SBOX[prev[12]];
        nk = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) nk[i] = prev[i] ^ t[i];
            else       nk[i] = prev[i] ^ nk[i-4];
        end
        return nk;
    endfunction

endpackage

// File: rtl/aes_decryptor_inv_round.sv
// aes_inv_round: one combinational AES inverse-cipher round.
//   state      in  current 128-bit state
//   round_key  in  round key added this round
//   last_round in  1 = final round, InvMixColumns skipped
//   next_state out InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key)
module aes_inv_round
    import aes_model_pack::*;
(
    input  byte_table state,
    input  byte_table round_key,
    input  logic      last_round,
    output byte_table next_state
);

    byte_table sr;
    byte_table ak;
    byte_table mc;

    always_comb begin
        sr = '0;
        ak = '0;
        mc = '0;
        // Bytes are column-major (index = row + 4*col); row r rotates right by r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4*c] = state[r + 4*((c - r + 4) % 4)];
            end
        end
        for (int i = 0; i < 16; i++) begin
            ak[i] = INV_SBOX[sr[i]] ^ round_key[i];
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = gf_mul(ak[4*c], 4'he) ^ gf_mul(ak[4*c+1], 4'hb) ^ gf_mul(ak[4*c+2], 4'hd) ^ gf_mul(ak[4*c+3], 4'h9);
            mc[4*c+1] = gf_mul(ak[4*c], 4'h9) ^ gf_mul(ak[4*c+1], 4'he) ^ gf_mul(ak[4*c+2], 4'hb) ^ gf_mul(ak[4*c+3], 4'hd);
            mc[4*c+2] = gf_mul(ak[4*c], 4'hd) ^ gf_mul(ak[4*c+1], 4'h9) ^ gf_mul(ak[4*c+2], 4'he) ^ gf_mul(ak[4*c+3], 4'hb);
            mc[4*c+3] = gf_mul(ak[4*c], 4'hb) ^ gf_mul(ak[4*c+1], 4'hd) ^ gf_mul(ak[4*c+2], 4'h9) ^ gf_mul(ak[4*c+3], 4'he);
        end
        next_state = last_round ? ak : mc;
    end

endmodule

// File: rtl/aes_decryptor.sv
// aes_decryptor: iterative AES-128 decryptor, one inverse round per clk.
// A key load expands all 11 round keys (10 cycles); each ciphertext then
// takes 10 cycles and the result is held until plain_ready.
//   clk, rst (async, active-low)
//   key/key_vld/key_ready                   key load handshake
//   cipher_block/cipher_block_vld/cipher_ready  ciphertext handshake
//   plain_block/plain_block_vld/plain_ready  plaintext handshake
//   block_cnt (only with AES_DEC_BLOCK_CNT_EN)  plaintext handshakes since key load
//
// state  | meaning
// IDLE   | no valid key, waiting for a key load
// EXPAND | computing rk[1..10], one per cycle
// READY  | keys valid, waiting for ciphertext or a new key
// ROUND  | inverse rounds, cnt 9 down to 0
// DONE   | plaintext valid, waiting for plain_ready
module aes_decryptor
    import aes_model_pack::*;
(
    input  logic      clk,
    input  logic      rst,
    input  byte_table key,
    input  logic      key_vld,
    output logic      key_ready,
    input  byte_table cipher_block,
    input  logic      cipher_block_vld,
    output logic      cipher_ready,
    output byte_table plain_block,
    output logic      plain_block_vld,
    input  logic      plain_ready
`ifdef AES_DEC_BLOCK_CNT_EN
    ,
    output logic [31:0] block_cnt
`endif
);

    dec_state_e state_q;
    dec_state_e state_d;
    logic [3:0] cnt_q;
    logic [0:NUM_ROUNDS][127:0] rk_q;
    byte_table  blk_q;
    byte_table  round_out;
    logic       key_acc;
    logic       blk_acc;

    assign key_acc = key_vld & key_ready;
    assign blk_acc = cipher_block_vld & cipher_ready;

    aes_inv_round u_inv_round (
        .state      (blk_q),
        .round_key  (rk_q[cnt_q]),
        .last_round (cnt_q == 4'd0),
        .next_state (round_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        key_ready       = 1'b0;
        cipher_ready    = 1'b0;
        plain_block_vld = 1'b0;
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted.
                key_ready = rst;
                if (key_vld) state_d = EXPAND;
            end
            EXPAND: begin
                if (cnt_q == 4'(NUM_ROUNDS)) state_d = READY;
            end
            READY: begin
                key_ready    = 1'b1;
                cipher_ready = !key_vld;
                if (key_vld)               state_d = EXPAND;
                else if (cipher_block_vld) state_d = ROUND;
            end
            ROUND: begin
                if (cnt_q == 4'd0) state_d = DONE;
            end
            DONE: begin
                plain_block_vld = 1'b1;
                if (plain_ready) state_d = READY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= 4'd0;
            rk_q        <= '0;
            blk_q       <= '0;
            plain_block <= '0;
        end else if (key_acc) begin
            rk_q[0] <= key;
            cnt_q   <= 4'd1;
        end else if (blk_acc) begin
            blk_q <= cipher_block ^ rk_q[NUM_ROUNDS];
            cnt_q <= 4'(NUM_ROUNDS - 1);
        end else if (state_q == EXPAND) begin
            rk_q[cnt_q] <= next_round_key(rk_q[cnt_q - 4'd1], RCON[cnt_q - 4'd1]);
            if (cnt_q != 4'(NUM_ROUNDS)) cnt_q <= cnt_q + 4'd1;
        end else if (state_q == ROUND) begin
            blk_q <= round_out;
            if (cnt_q == 4'd0) plain_block <= round_out;
            else               cnt_q <= cnt_q - 4'd1;
        end
    end

`ifdef AES_DEC_BLOCK_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               block_cnt <= 32'd0;
        else if (key_acc)                       block_cnt <= 32'd0;
        else if (plain_block_vld && plain_ready) block_cnt <= block_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_aes_decryptor.sv
// Directed bench for aes_decryptor using FIPS-197 vectors.
module tb_aes_decryptor;
    import aes_model_pack::*;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;

    logic      clk = 1'b0;
    logic      rst;
    byte_table key;
    logic      key_vld;
    logic      key_ready;
    byte_table cipher_block;
    logic      cipher_block_vld;
    logic      cipher_ready;
    byte_table plain_block;
    logic      plain_block_vld;
    logic      plain_ready;
`ifdef AES_DEC_BLOCK_CNT_EN
    logic [31:0] block_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_accept = 0;
    int prev_accept = 0;

    aes_decryptor dut (
        .clk              (clk),
        .rst              (rst),
        .key              (key),
        .key_vld          (key_vld),
        .key_ready        (key_ready),
        .cipher_block     (cipher_block),
        .cipher_block_vld (cipher_block_vld),
        .cipher_ready     (cipher_ready),
        .plain_block      (plain_block),
        .plain_block_vld  (plain_block_vld),
        .plain_ready      (plain_ready)
`ifdef AES_DEC_BLOCK_CNT_EN
        ,
        .block_cnt        (block_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else             n_pass++;
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp);
`ifdef AES_DEC_BLOCK_CNT_EN
        check(tag, block_cnt, exp);
`else
        if (exp == 32'hffff_ffff) $display("note: %s", tag);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k, input string tag);
        int n;
        key     = k;
        key_vld = 1'b1;
        n = 0;
        while (!key_ready && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_key_ready"}, key_ready, 1'b1);
        tick();
        key_vld = 1'b0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            check({tag, "_exp_key_ready"}, key_ready, 1'b0);
            check({tag, "_exp_cipher_ready"}, cipher_ready, 1'b0);
            tick();
        end
        check({tag, "_ready_after_exp"}, key_ready, 1'b1);
        check_cnt({tag, "_cnt_cleared"}, 32'd0);
    endtask

    task automatic decrypt(input logic [127:0] c, input logic [127:0] p, input string tag);
        int n;
        cipher_block     = c;
        cipher_block_vld = 1'b1;
        n = 0;
        while (!cipher_ready && n < 40) begin
            tick();
            n++;
        end
        if (!cipher_ready) begin
            check({tag, "_accept_timeout"}, 1'b0, 1'b1);
            cipher_block_vld = 1'b0;
            return;
        end
        tick();
        prev_accept      = last_accept;
        last_accept      = cyc;
        cipher_block_vld = 1'b0;
        n = 0;
        while (!plain_block_vld && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 128'(cyc - last_accept), 128'(10));
        check({tag, "_plain"}, plain_block, p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits_rdy;
        int hits_vld;
        rst = 1'b0;
        key = '0;
        key_vld = 1'b0;
        cipher_block = '0;
        cipher_block_vld = 1'b0;
        plain_ready = 1'b0;
        tick();
        tick();
        check("rst_key_ready", key_ready, 1'b0);
        check("rst_cipher_ready", cipher_ready, 1'b0);
        check("rst_plain_vld", plain_block_vld, 1'b0);
        check("rst_plain_block", plain_block, 128'h0);
        check_cnt("rst_block_cnt", 32'd0);

        rst = 1'b1;
        #1;
        check("idle_key_ready", key_ready, 1'b1);
        check("idle_cipher_ready", cipher_ready, 1'b0);

        // First vector, output held in DONE for 5 cycles.
        load_key(K1, "k1");
        decrypt(C1, P1, "v1");
        key     = K2;
        key_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_vld", plain_block_vld, 1'b1);
            check("hold_plain", plain_block, P1);
            check("hold_cipher_ready", cipher_ready, 1'b0);
            check("hold_key_ready", key_ready, 1'b0);
            check_cnt("hold_block_cnt", 32'd0);
            tick();
        end
        key_vld     = 1'b0;
        plain_ready = 1'b1;
        tick();
        check("hs_vld_low", plain_block_vld, 1'b0);
        check_cnt("hs_block_cnt", 32'd1);

        // Back-to-back blocks with plain_ready high.
        decrypt(C1, P1, "b2b_1");
        decrypt(C1, P1, "b2b_2");
        check("b2b_gap_ge12", 128'((last_accept - prev_accept) >= 12), 128'(1));
        tick();
        check("b2b_vld_low", plain_block_vld, 1'b0);
        check_cnt("b2b_block_cnt", 32'd3);

        // Key and cipher presented together: key wins.
        key              = K2;
        key_vld          = 1'b1;
        cipher_block     = C2;
        cipher_block_vld = 1'b1;
        #1;
        check("coll_cipher_ready", cipher_ready, 1'b0);
        check("coll_key_ready", key_ready, 1'b1);
        tick();
        key_vld = 1'b0;
        check_cnt("coll_cnt_cleared", 32'd0);
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            check("coll_exp_cipher_ready", cipher_ready, 1'b0);
            check("coll_exp_key_ready", key_ready, 1'b0);
            tick();
        end
        decrypt(C2, P2, "v2");
        tick();
        check_cnt("v2_block_cnt", 32'd1);

        // Reset in the middle of the rounds.
        load_key(K1, "k1b");
        cipher_block     = C1;
        cipher_block_vld = 1'b1;
        #1;
        check("abort_cipher_ready", cipher_ready, 1'b1);
        tick();
        cipher_block_vld = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        #1;
        check("abort_vld", plain_block_vld, 1'b0);
        check("abort_key_ready", key_ready, 1'b0);
        check("abort_plain_block", plain_block, 128'h0);
        check_cnt("abort_block_cnt", 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("abort_idle_key_ready", key_ready, 1'b1);
        cipher_block_vld = 1'b1;
        hits_rdy = 0;
        hits_vld = 0;
        for (int i = 0; i < 15; i++) begin
            if (cipher_ready) hits_rdy++;
            if (plain_block_vld) hits_vld++;
            tick();
        end
        cipher_block_vld = 1'b0;
        check("nokey_cipher_ready_cycles", 128'(hits_rdy), 128'(0));
        check("nokey_plain_vld_cycles", 128'(hits_vld), 128'(0));

        load_key(K1, "k1c");
        decrypt(C1, P1, "v3");
        tick();
        check_cnt("v3_block_cnt", 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_decryptor.md
AES_DECRYPTOR -- requirements
Module: aes_decryptor

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with the ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 key  in  128  aes_model_pack::byte_table cipher key; FIPS-197 byte 0 in bits [127:120].
REQ-005 key_vld  in  1  key load request.
REQ-006 key_ready  out  1  key load accepted when key_vld and key_ready are both high at a clk edge.
REQ-007 cipher_block  in  128  aes_model_pack::byte_table ciphertext.
REQ-008 cipher_block_vld  in  1  ciphertext valid.
REQ-009 cipher_ready  out  1  ciphertext accepted when cipher_block_vld and cipher_ready are both high at a clk edge.
REQ-010 plain_block  out  128  aes_model_pack::byte_table decrypted block.
REQ-011 plain_block_vld  out  1  plaintext valid.
REQ-012 plain_ready  in  1  downstream accept.

Function
REQ-013 SHALL implement the FIPS-197 AES-128 inverse cipher iteratively, one round per clk.
REQ-014 SHALL use an FSM with the states IDLE, EXPAND, READY, ROUND and DONE.
REQ-015 IDLE: no valid key; key_ready=1 and cipher_ready=0; key accepted -> EXPAND.
REQ-016 EXPAND: compute one round key per cycle into an 11x128 key store (rk[0]=key), 10 cycles, then -> READY; key_ready=0 and cipher_ready=0 throughout.
REQ-017 READY: key_ready=1; cipher_ready=!key_vld, so a key load wins over a simultaneous cipher block; a key accepted here -> EXPAND and the old keys are discarded.
REQ-018 Cipher accepted in READY: state <= cipher_block ^ rk[10], round counter <= 9, -> ROUND.
REQ-019 ROUND: each cycle, state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[cnt]) for cnt 9..1; at cnt 0, omit InvMixColumns, load plain_block, -> DONE.
REQ-020 Latency SHALL be exactly 10 clk edges from the accept edge to the edge that raises plain_block_vld.
REQ-021 DONE: plain_block_vld=1 and plain_block is held stable until plain_ready=1 at an edge, then -> READY.
REQ-022 With plain_block_vld and plain_ready both high, the next block MAY be accepted no earlier than the following cycle (no overlap).
REQ-023 key_ready=0 and cipher_ready=0 in ROUND and DONE; key_vld is ignored there.
REQ-024 All arithmetic SHALL be GF(2^8) with polynomial 0x11B; the round counter SHALL be 4 bits and never wrap past 0.

Reset
REQ-025 rst low -> state IDLE, key store invalid, key_ready=0 while in reset, cipher_ready=0, plain_block_vld=0, plain_block=0, counters=0.
REQ-026 Reset asserted mid-EXPAND or mid-ROUND SHALL abort the operation; after release the block is in IDLE and requires a new key.

Configuration
REQ-027 The macro AES_DEC_BLOCK_CNT_EN SHALL add the output block_cnt (32 bits), counting accepted plain_block handshakes, wrapping 0xFFFFFFFF->0, and cleared by reset and by every key acceptance.
REQ-028 Without AES_DEC_BLOCK_CNT_EN, the port and the counter SHALL be absent.

Structure
REQ-029 aes_model_pack SHALL hold byte_table, the inverse S-box table, the Rcon table, the forward S-box (for key expansion) and the constant NUM_ROUNDS=10.
REQ-030 One sub-module, aes_inv_round, SHALL be combinational: inputs state, round_key and last_round flag; output next state.

Verification
REQ-031 Load key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32 -> plain_block 3243f6a8885a308d313198a2e0370734 exactly 10 edges after accept.
REQ-032 Load key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> plain 00112233445566778899aabbccddeeff.
REQ-033 Hold plain_ready=0 for 5 cycles in DONE -> plain_block is stable, cipher_ready=0, and with AES_DEC_BLOCK_CNT_EN block_cnt is unchanged until the handshake.
REQ-034 Drive key_vld and cipher_block_vld together in READY -> key accepted, cipher not accepted, cipher_ready=0 for 10 EXPAND cycles.
REQ-035 Pull rst low at round 5 -> plain_block_vld=0, IDLE; a cipher presented afterwards is not accepted until a new key is loaded.
REQ-036 Decrypt the two REQ-031 blocks back-to-back with plain_ready=1 -> second result is correct, and the accept edges are at least 12 edges apart.
